// File: rtl/m_and_arbiter.sv
// m_and_arbiter
//   Round-robin arbiter that shares one registered bitwise AND unit among
//   N_REQ requesters and returns a & b with the requester index on a single
//   valid/ready response channel.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [N_REQ]        requester i has an operand pair pending
//   req_ready  : [N_REQ]        one-hot (or zero) grant for this cycle
//   req_a      : [N_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : [N_REQ*WIDTH]  operand B, same slicing
//   rsp_valid  : response register holds a result
//   rsp_ready  : consumer accepts the response
//   rsp_data   : [WIDTH] a & b of the granted pair
//   rsp_id     : [IDW]   index of the requester that produced rsp_data
//   busy       : mirrors rsp_valid
module m_and_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_p1;
  logic [IDW-1:0]   ptr_p1;
  logic [WIDTH-1:0] data_p1;
  logic [IDW-1:0]   id_p1;

  logic             can_accept;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             grant;
  int               j;

  // Stage p0: combinational round-robin grant search
  assign can_accept = (state_p1 == ST_EMPTY) || rsp_ready;

  // Search upward from ptr, wrapping at N_REQ so non-power-of-two counts
  // never visit unused index values.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    a_sel     = '0;
    b_sel     = '0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_p1) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_found && req_valid[IDW'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
        a_sel     = req_a[j*WIDTH +: WIDTH];
        b_sel     = req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst_n so no requester sees a grant while reset is asserted.
  assign grant     = rst_n && can_accept && gnt_found;
  assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Stage p1: registered AND result, requester id and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= ST_EMPTY;
      ptr_p1   <= '0;
      data_p1  <= '0;
      id_p1    <= '0;
    end else if (grant) begin
      state_p1 <= ST_FULL;
      ptr_p1   <= ptr_nxt;
      data_p1  <= a_sel & b_sel;
      id_p1    <= gnt_idx;
    end else if ((state_p1 == ST_FULL) && rsp_ready) begin
      state_p1 <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state_p1 == ST_FULL);
  assign busy      = rsp_valid;
  assign rsp_data  = data_p1;
  assign rsp_id    = id_p1;

endmodule

// File: tb/tb_m_and_arbiter.sv
module tb_m_and_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit        m_valid;
  bit [W-1:0] m_data;
  int        m_id;
  int        m_ptr;

  m_and_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Which requester the rules say is granted now, or -1.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (m_ptr + k) % N;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] v;
    g = exp_grant();
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance one clock: model follows the edge, returns at the next negedge.
  task automatic tick();
    int g;
    logic [W-1:0] a, b;
    g = exp_grant();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      a = req_a[g*W +: W];
      b = req_b[g*W +: W];
      m_data  = a & b;
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1; req_a = '1; req_b = '1;
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    tick(); tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0/0", rsp_valid, busy); end
    checks++;
    if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_data got %h/%0d want 00/0", rsp_data, rsp_id); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", req_ready); end
    tick();
  endtask

  task automatic test_single();
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'hF0;
    req_b[2*W +: W] = 8'h3C;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd2)
      begin errors++; $display("FAIL single_rsp got v%b %h id%0d want v1 30 id2", rsp_valid, rsp_data, rsp_id); end
  endtask

  task automatic test_rotation();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'hFF;
      req_b[i*W +: W] = W'(i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != k % N || int'(rsp_data) != k % N)
        begin errors++; $display("FAIL rotation_%0d got v%b id%0d d%h want v1 id%0d", k, rsp_valid, rsp_id, rsp_data, k % N); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  hd;
    logic [IW-1:0] hi;
    hd = rsp_data; hi = rsp_id;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d got %b want 0000", k, req_ready); end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_id !== hi)
        begin errors++; $display("FAIL bp_hold_%0d got v%b %h id%0d want v1 %h id%0d", k, rsp_valid, rsp_data, rsp_id, hd, hi); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", req_ready); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h02)
      begin errors++; $display("FAIL bp_release_rsp got v%b id%0d %h want v1 id2 02", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b want 0001", req_ready); end
    tick();
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_second got %b want 1000", req_ready); end
    tick();
    checks++;
    if (rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_rsp_id got %0d want 3", rsp_id); end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1*W +: W] = 8'hAA;
    req_b[1*W +: W] = 8'hFF;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0)
      begin errors++; $display("FAIL async_reset got v%b %h id%0d want v0 00 id0", rsp_valid, rsp_data, rsp_id); end
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001)
      begin errors++; $display("FAIL async_after got v%b rdy%b want v0 rdy0001", rsp_valid, req_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] er;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          req_valid[i]     = ($urandom_range(0, 2) != 0);
          req_a[i*W +: W]  = W'($urandom);
          req_b[i*W +: W]  = W'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      checks++;
      if (req_ready !== er) begin errors++; $display("FAIL rand_ready_%0d got %b want %b", c, req_ready, er); end
      pend = req_valid & ~er;
      tick();
      checks++;
      if (rsp_valid !== m_valid || busy !== m_valid ||
          (m_valid && (rsp_data !== m_data || int'(rsp_id) != m_id)))
        begin errors++; $display("FAIL rand_rsp_%0d got v%b %h id%0d want v%b %h id%0d", c, rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
